svc_soc_io_uart_fifo: RTL and testbench
=======================================

Name: svc_soc_io_uart_fifo

Overview:
Memory-mapped 8N1 UART peripheral on the SoC I/O bus, the successor to the fixed-rate TX-only UART in the I/O register bank. Adds a parametrised TX FIFO, a full receiver with its own RX FIFO, a runtime-programmable baud divisor, and sticky error flags. Sits beside the I/O register bank on the shared io_* bus. It decodes only its own 16-byte window.

Parameters:
CLOCK_FREQ, 100_000_000, system clock in Hz
BAUD_RATE, 115_200, reset baud; reset divisor = CLOCK_FREQ/BAUD_RATE (integer)
TX_FIFO_DEPTH, 16, TX FIFO entries; power of 2, >=2
RX_FIFO_DEPTH, 16, RX FIFO entries; power of 2, >=2
BASE_ADDR, 32'h0000_0100, window base; 16-byte aligned

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
io_ren  in  1  read strobe
io_raddr  in  32  read byte address
io_rdata  out  32  read data, registered
io_wen  in  1  write strobe
io_waddr  in  32  write byte address
io_wdata  in  32  write data
io_wstrb  in  4  byte write strobes
uart_rx  in  1  serial input, asynchronous
uart_tx  out  1  serial output, idle high

Behaviour:
- Reset (asynchronous, active-low): uart_tx=1, io_rdata=0, FIFOs empty, sticky flags 0, divisor=CLOCK_FREQ/BAUD_RATE, TX/RX FSMs IDLE. Reset mid-frame aborts the frame: uart_tx=1 immediately.
- Decode: hit when addr[31:4]==BASE_ADDR[31:4]; register select = addr[3:2].
- Read latency is 1 cycle. io_rdata is valid the cycle after io_ren and is 0 after a miss or when no read was issued. io_ren and io_wen may both be asserted in one cycle; both act.
- 0x0 TXDATA (W): wstrb[0] pushes wdata[7:0]. If FIFO is full, the byte is dropped and tx_overflow is set. A push while full in the same cycle the shifter pops is accepted. Reads return 0.
- 0x4 RXDATA (R): returns {23'b0, valid, byte}. If not empty: valid=1, head byte is returned and popped. If empty: returns 0 and nothing is popped. Writes are ignored.
- 0x8 STATUS (R/W1C): bit0 tx_full, bit1 tx_empty, bit2 tx_busy (shifter active), bit3 rx_empty, bit4 rx_full, bit5 tx_overflow, bit6 rx_overflow, bit7 rx_frame_err. Writing 1 to bits 5-7 with wstrb[0] clears them. If set and clear occur in the same cycle, set wins.
- 0xC BAUD_DIV (R/W): bits[15:0] hold clocks per bit, honouring wstrb[1:0]. Values <4 are stored as 4. Each FSM latches the divisor at frame start, so a change takes effect on the next frame in each direction.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE with FIFO non-empty: pop and enter START. uart_tx falls on the cycle after the pop.
  - Each state lasts div clocks. DATA sends 8 bits LSB first. STOP drives 1.
  - STOP -> START directly if FIFO non-empty (back-to-back frames, no idle gap).
  - tx_busy = state != IDLE.
- RX path: uart_rx passes through a 2-flop synchronizer, reset value 1.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge enters START.
  - START: sample at div/2. If high, it is a glitch: return to IDLE with no flag set.
  - DATA: 8 samples spaced div apart, LSB first.
  - STOP: sample after div. If 1, push the byte; if the FIFO is full, drop the byte and set rx_overflow. If 0, set rx_frame_err, discard the byte, and wait for line high before returning to IDLE.
  - A push and a RXDATA pop in the same cycle on a full FIFO: both act, no overflow.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full/empty derive from MSB compare.

Test Plan:
- Reset, CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 -> uart_tx=1; read STATUS=0x0000_000A; read BAUD_DIV=0x0000_000A; read at BASE+0x10 returns 0.
- Write 0x55 to TXDATA -> uart_tx low 1 cycle later for 10 clocks, then 1,0,1,0,1,0,1,0 (10 clocks each), then stop high; tx_busy=1 for 100 clocks; STATUS returns to 0x0A.
- TX_FIFO_DEPTH=4: write 0x01..0x06 on consecutive cycles -> frames 0x01..0x05 sent back-to-back with no idle gap; 0x06 dropped; STATUS bit5=1; write 0x20 to STATUS -> bit5=0.
- Drive 0xA3 8N1 at 10 clk/bit on uart_rx -> rx_empty=0; RXDATA read=0x0000_01A3; next RXDATA read=0x0000_0000.
- Frame with stop bit=0 -> bit7 set, rx_empty stays 1. 3-cycle low glitch -> no byte, no flag. RX_FIFO_DEPTH=2 with 3 frames unread -> rx_overflow=1, two bytes readable.
- Write BAUD_DIV=20 mid-TX-frame -> current frame finishes at 10 clk/bit, next frame runs at 20. Write 2 -> reads back 4. Assert rst_n=0 mid-frame -> uart_tx=1 in the same cycle, STATUS=0x0A after release.

Source files
------------

// File: rtl/svc_soc_io_uart_fifo.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, programmable baud divisor and
// sticky error flags, decoded from a 16-byte window on the shared io_* bus.
module svc_soc_io_uart_fifo #(
  parameter int          CLOCK_FREQ    = 100_000_000,
  parameter int          BAUD_RATE     = 115_200,
  parameter int          TX_FIFO_DEPTH = 16,
  parameter int          RX_FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_ren,
  input  logic [31:0] io_raddr,
  output logic [31:0] io_rdata,
  input  logic        io_wen,
  input  logic [31:0] io_waddr,
  input  logic [31:0] io_wdata,
  input  logic [3:0]  io_wstrb,
  input  logic        uart_rx,
  output logic        uart_tx
);
  localparam int TAW = $clog2(TX_FIFO_DEPTH);
  localparam int RAW = $clog2(RX_FIFO_DEPTH);
  localparam int DIV_RAW = CLOCK_FREQ / BAUD_RATE;
  localparam logic [15:0] DIV_RST = (DIV_RAW < 4) ? 16'd4 : 16'(DIV_RAW);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT} st_t;

  logic rhit, whit;
  assign rhit = io_ren && (io_raddr[31:4] == BASE_ADDR[31:4]);
  assign whit = io_wen && (io_waddr[31:4] == BASE_ADDR[31:4]);

  logic tx_push_req, st_wr, div_wr, rx_rd;
  assign tx_push_req = whit && io_waddr[3:2] == 2'd0 && io_wstrb[0];
  assign st_wr       = whit && io_waddr[3:2] == 2'd2 && io_wstrb[0];
  assign div_wr      = whit && io_waddr[3:2] == 2'd3 && |io_wstrb[1:0];
  assign rx_rd       = rhit && io_raddr[3:2] == 2'd1;

  logic unused_ok;
  assign unused_ok = ^{io_raddr[1:0], io_waddr[1:0], io_wdata[31:16], io_wstrb[3:2]};

  logic [15:0] div, div_new;
  assign div_new = {io_wstrb[1] ? io_wdata[15:8] : div[15:8],
                    io_wstrb[0] ? io_wdata[7:0]  : div[7:0]};

  // ---------------- TX FIFO + shifter ----------------
  logic [7:0]   tx_mem [TX_FIFO_DEPTH];
  logic [TAW:0] tx_wp, tx_rp;
  logic         tx_empty, tx_full, tx_pop, tx_push, tx_end;
  st_t          tx_st;
  logic [15:0]  tx_cnt, tx_div_l;
  logic [7:0]   tx_sh;
  logic [2:0]   tx_bit;

  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign tx_end   = tx_cnt == tx_div_l - 16'd1;
  // Popping at the end of STOP chains frames with no idle gap.
  assign tx_pop   = !tx_empty && (tx_st == IDLE || (tx_st == STOP && tx_end));
  assign tx_push  = tx_push_req && (!tx_full || tx_pop);

  always_ff @(posedge clk) if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= io_wdata[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp <= '0; tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st <= IDLE; tx_cnt <= '0; tx_div_l <= DIV_RST;
      tx_sh <= '0; tx_bit <= '0; uart_tx <= 1'b1;
    end else if (tx_pop) begin
      tx_st <= START; tx_cnt <= '0; tx_div_l <= div;
      tx_sh <= tx_mem[tx_rp[TAW-1:0]]; uart_tx <= 1'b0;
    end else begin
      case (tx_st)
        IDLE: ;
        START: if (tx_end) begin
          tx_st <= DATA; tx_cnt <= '0; tx_bit <= '0;
          uart_tx <= tx_sh[0]; tx_sh <= {1'b0, tx_sh[7:1]};
        end else tx_cnt <= tx_cnt + 16'd1;
        DATA: if (tx_end) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_st <= STOP; uart_tx <= 1'b1;
          end else begin
            tx_bit <= tx_bit + 3'd1;
            uart_tx <= tx_sh[0]; tx_sh <= {1'b0, tx_sh[7:1]};
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        STOP: if (tx_end) tx_st <= IDLE;
              else tx_cnt <= tx_cnt + 16'd1;
        default: tx_st <= IDLE;
      endcase
    end
  end

  // ---------------- RX sampler + FIFO ----------------
  logic [1:0]   rx_sync;
  logic         rx_s, rx_prev, rx_end, rx_push, rx_wr, rx_pop, fe_set;
  st_t          rx_st;
  logic [15:0]  rx_cnt, rx_div_l;
  logic [7:0]   rx_sh;
  logic [2:0]   rx_bit;
  logic [7:0]   rx_mem [RX_FIFO_DEPTH];
  logic [RAW:0] rx_wp, rx_rp;
  logic         rx_empty, rx_full;

  assign rx_s     = rx_sync[1];
  assign rx_end   = rx_cnt == rx_div_l - 16'd1;
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
  assign rx_pop   = rx_rd && !rx_empty;
  assign rx_push  = rx_st == STOP && rx_end && rx_s;
  assign fe_set   = rx_st == STOP && rx_end && !rx_s;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);

  always_ff @(posedge clk) if (rx_wr) rx_mem[rx_wp[RAW-1:0]] <= rx_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11; rx_prev <= 1'b1; rx_st <= IDLE; rx_cnt <= '0;
      rx_div_l <= DIV_RST; rx_sh <= '0; rx_bit <= '0; rx_wp <= '0; rx_rp <= '0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
      if (rx_wr)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      case (rx_st)
        IDLE: if (rx_prev && !rx_s) begin
          rx_st <= START; rx_cnt <= '0; rx_div_l <= div;
        end
        // Line back high at mid-start is treated as noise, not a frame.
        START: if (rx_cnt == (rx_div_l >> 1)) begin
          rx_cnt <= '0; rx_bit <= '0;
          rx_st <= rx_s ? IDLE : DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        DATA: if (rx_end) begin
          rx_cnt <= '0; rx_sh <= {rx_s, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_st <= STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + 16'd1;
        STOP: if (rx_end) rx_st <= rx_s ? IDLE : WAIT;
              else rx_cnt <= rx_cnt + 16'd1;
        WAIT: if (rx_s) rx_st <= IDLE;
        default: rx_st <= IDLE;
      endcase
    end
  end

  // ---------------- registers ----------------
  logic tx_ovf, rx_ovf, frame_err;
  logic [31:0] rd_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf <= 1'b0; rx_ovf <= 1'b0; frame_err <= 1'b0; div <= DIV_RST;
    end else begin
      tx_ovf    <= (tx_push_req && tx_full && !tx_pop) | (tx_ovf & ~(st_wr & io_wdata[5]));
      rx_ovf    <= (rx_push && rx_full && !rx_pop) | (rx_ovf & ~(st_wr & io_wdata[6]));
      frame_err <= fe_set | (frame_err & ~(st_wr & io_wdata[7]));
      if (div_wr) div <= (div_new < 16'd4) ? 16'd4 : div_new;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rhit) begin
      case (io_raddr[3:2])
        2'd1: if (!rx_empty) rd_mux = {23'b0, 1'b1, rx_mem[rx_rp[RAW-1:0]]};
        2'd2: rd_mux = {24'b0, frame_err, rx_ovf, tx_ovf, rx_full, rx_empty,
                        tx_st != IDLE, tx_empty, tx_full};
        2'd3: rd_mux = {16'b0, div};
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) io_rdata <= '0;
    else        io_rdata <= rd_mux;
  end
endmodule

// File: tb/tb_svc_soc_io_uart_fifo.sv
// Scoreboard bench: reads and TX frames queue expectations; independent
// monitors pop and compare against io_rdata and the decoded uart_tx line.
module tb_svc_soc_io_uart_fifo;
  localparam logic [31:0] B = 32'h0000_0100;

  logic clk = 0, rst_n = 0;
  logic io_ren = 0, io_wen = 0, uart_rx = 1;
  logic [31:0] io_raddr = 0, io_waddr = 0, io_wdata = 0, io_rdata;
  logic [3:0] io_wstrb = 0;
  logic uart_tx;

  svc_soc_io_uart_fifo #(
    .CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000),
    .TX_FIFO_DEPTH(4), .RX_FIFO_DEPTH(2), .BASE_ADDR(B)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_ren(io_ren), .io_raddr(io_raddr),
    .io_rdata(io_rdata), .io_wen(io_wen), .io_waddr(io_waddr),
    .io_wdata(io_wdata), .io_wstrb(io_wstrb), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  string rd_n[$];
  logic [31:0] rd_e[$];
  logic [7:0] tx_b[$];
  int tx_d[$];
  int starts[$];
  logic rv = 0, rv2 = 0, mon_en = 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", n, a, e);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rv  <= io_ren && rst_n;
    rv2 <= rv;
  end

  // Read monitor: data is due the cycle after each accepted read strobe.
  always @(negedge clk) begin
    if (rv) begin
      if (rd_e.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got 0x%08h want no read", io_rdata);
      end else chk(rd_n.pop_front(), io_rdata, rd_e.pop_front());
    end else if (rv2) chk("rdata_idle", io_rdata, 32'h0);
  end

  // TX monitor: decode frames mid-bit using the expected per-frame divisor.
  initial begin
    logic prev;
    logic [7:0] b;
    int d;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en && prev === 1'b1 && uart_tx === 1'b0) begin
        starts.push_back(cyc);
        if (tx_b.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected_frame: got start at cycle %0d want none", cyc);
        end else begin
          d = tx_d[0];
          repeat (d / 2) @(negedge clk);
          chk("tx_start_bit", uart_tx, 1'b0);
          for (int i = 0; i < 8; i++) begin
            repeat (d) @(negedge clk);
            b[i] = uart_tx;
          end
          repeat (d) @(negedge clk);
          chk("tx_stop_bit", uart_tx, 1'b1);
          void'(tx_d.pop_front());
          chk("tx_byte", b, tx_b.pop_front());
        end
        prev = 1'b1;
      end else prev = uart_tx;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    rd_n.push_back(n); rd_e.push_back(e);
    io_ren = 1; io_raddr = a;
    step(1);
    io_ren = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    io_wen = 1; io_waddr = a; io_wdata = d; io_wstrb = s;
    step(1);
    io_wen = 0;
  endtask

  task automatic expect_tx(input logic [7:0] b, input int d);
    tx_b.push_back(b); tx_d.push_back(d);
  endtask

  task automatic wait_tx(input int lim);
    int n = 0;
    while (tx_b.size() != 0 && n < lim) begin step(1); n++; end
    chk("tx_drain_timeout", tx_b.size(), 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb, input int d);
    uart_rx = 0; step(d);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; step(d); end
    uart_rx = stopb; step(d);
    uart_rx = 1; step(20);
  endtask

  initial begin
    int c0, s0;
    step(3);
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_rdata", io_rdata, 32'h0);
    rst_n = 1;
    step(2);

    rd(B + 8, 32'h0A, "status_rst");
    rd(B + 12, 32'h0A, "div_rst");
    rd(B + 16, 32'h0, "miss_read");
    rd(B + 0, 32'h0, "txdata_read");
    rd(B + 4, 32'h0, "rxdata_empty");

    // Single frame 0x55, with exact busy window
    starts.delete();
    expect_tx(8'h55, 10);
    c0 = cyc;
    wr(B, 32'h55, 4'hF);
    step(50);
    rd(B + 8, 32'h0E, "status_busy_mid");
    wait_tx(300);
    chk("tx_start_latency", starts.size() > 0 ? starts[0] : -1, c0 + 2);
    s0 = (starts.size() > 0) ? starts[0] : cyc;
    while (cyc < s0 + 99) step(1);
    rd(B + 8, 32'h0E, "status_busy_last");
    rd(B + 8, 32'h0A, "status_busy_end");

    // TX FIFO overflow with back-to-back frames
    starts.delete();
    for (int i = 1; i <= 5; i++) expect_tx(8'(i), 10);
    for (int i = 1; i <= 6; i++) wr(B, i, 4'hF);
    rd(B + 8, 32'h2D, "status_tx_ovf");
    wr(B + 8, 32'h20, 4'hF);
    rd(B + 8, 32'h0D, "status_tx_ovf_clr");
    wait_tx(1000);
    step(10);
    rd(B + 8, 32'h0A, "status_tx_drained");
    chk("b2b_frames", starts.size(), 5);
    for (int i = 0; i < 4 && i + 1 < starts.size(); i++)
      chk("b2b_gap", starts[i+1] - starts[i], 100);

    // RX good frame
    send_rx(8'hA3, 1'b1, 10);
    rd(B + 8, 32'h02, "status_rx_nonempty");
    rd(B + 4, 32'h1A3, "rxdata_a3");
    rd(B + 4, 32'h0, "rxdata_after_pop");

    // Framing error, then glitch
    send_rx(8'h5A, 1'b0, 10);
    rd(B + 8, 32'h8A, "status_frame_err");
    wr(B + 8, 32'h80, 4'h1);
    rd(B + 8, 32'h0A, "status_fe_clr");
    uart_rx = 0; step(3); uart_rx = 1; step(30);
    rd(B + 8, 32'h0A, "status_glitch");

    // RX overflow on a 2-entry FIFO
    send_rx(8'h11, 1'b1, 10);
    send_rx(8'h22, 1'b1, 10);
    send_rx(8'h33, 1'b1, 10);
    rd(B + 8, 32'h52, "status_rx_ovf");
    rd(B + 4, 32'h111, "rx_ovf_first");
    rd(B + 4, 32'h122, "rx_ovf_second");
    rd(B + 4, 32'h0, "rx_ovf_empty");
    rd(B + 8, 32'h4A, "status_rx_ovf_sticky");
    wr(B + 8, 32'h40, 4'h1);
    rd(B + 8, 32'h0A, "status_rx_ovf_clr");

    // Divisor change mid-frame takes effect on the next frame
    starts.delete();
    expect_tx(8'h11, 10);
    expect_tx(8'h22, 20);
    wr(B, 32'h11, 4'hF);
    wr(B, 32'h22, 4'hF);
    step(30);
    wr(B + 12, 32'd20, 4'hF);
    rd(B + 12, 32'd20, "div_20");
    wait_tx(1500);
    step(25);
    chk("baud_frames", starts.size(), 2);
    if (starts.size() == 2) chk("baud_gap", starts[1] - starts[0], 100);
    wr(B + 12, 32'd2, 4'hF);
    rd(B + 12, 32'd4, "div_min_clamp");
    wr(B + 12, 32'hFFFF_0C07, 4'h1);
    rd(B + 12, 32'h0007, "div_strb_lo");
    wr(B + 12, 32'h0000_0100, 4'h2);
    rd(B + 12, 32'h0107, "div_strb_hi");

    // Reset mid-frame
    wr(B + 12, 32'd30, 4'hF);
    mon_en = 0;
    wr(B, 32'h00, 4'hF);
    step(40);
    #2 rst_n = 0;
    #1 chk("rst_mid_tx", uart_tx, 1'b1);
    chk("rst_mid_rdata", io_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step(1);
    mon_en = 1;
    rd(B + 8, 32'h0A, "status_after_rst");
    rd(B + 12, 32'h0A, "div_after_rst");
    step(20);
    chk("tx_idle_after_rst", uart_tx, 1'b1);

    step(5);
    chk("rd_queue_left", rd_e.size(), 0);
    chk("tx_queue_left", tx_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
